// File: rtl/sd_block_read_sequencer.sv
// SPI-mode SD single-block read (CMD17) sequencer over a byte-exchange engine.
// Ports: MasterCLK/Reset; InitDone/ReadReq/BlockAddr request side;
// ByteStart/ByteOut/ByteDone/ByteIn engine side; CardCS chip select;
// DataOut/DataValid/DataReady stream; Busy/Done/Error/ErrorCode status.
module sd_block_read_sequencer #(
  parameter int ADDR_W        = 32,
  parameter int BLOCK_BYTES   = 512,
  parameter int RESP_TIMEOUT  = 8,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic              MasterCLK,
  input  logic              Reset,
  input  logic              InitDone,
  input  logic              ReadReq,
  input  logic [ADDR_W-1:0] BlockAddr,
  output logic              Busy,
  output logic              ByteStart,
  output logic [7:0]        ByteOut,
  input  logic              ByteDone,
  input  logic [7:0]        ByteIn,
  output logic              CardCS,
  output logic [7:0]        DataOut,
  output logic              DataValid,
  input  logic              DataReady,
  output logic              Done,
  output logic              Error,
  output logic [2:0]        ErrorCode
);

  localparam int DW = $clog2(BLOCK_BYTES);
  localparam int PMAX = (TOKEN_TIMEOUT > RESP_TIMEOUT) ?
                        TOKEN_TIMEOUT : RESP_TIMEOUT;
  localparam int PW = $clog2(PMAX + 1);
  localparam logic [DW-1:0] LAST_BEAT = DW'(BLOCK_BYTES - 1);
  localparam logic [PW-1:0] R1_LAST   = PW'(RESP_TIMEOUT - 1);
  localparam logic [PW-1:0] TOK_LAST  = PW'(TOKEN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, R1WAIT, TOKWAIT, DATA, CRC, TAIL, FIN
  } state_t;

  state_t        state;
  logic [31:0]   addr;
  logic [2:0]    idx;
  logic [PW-1:0] polls;
  logic [DW-1:0] beat;
  logic          pend;
  logic          failed;
  logic [7:0]    cmd_byte;

  always_comb begin
    cmd_byte = 8'h01;
    case (idx)
      3'd0:    cmd_byte = 8'h51;
      3'd1:    cmd_byte = addr[31:24];
      3'd2:    cmd_byte = addr[23:16];
      3'd3:    cmd_byte = addr[15:8];
      3'd4:    cmd_byte = addr[7:0];
      default: cmd_byte = 8'h01;
    endcase
  end

  // pend marks an exchange in flight; a new ByteStart is only
  // issued once it has been cleared by ByteDone.
  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      addr      <= '0;
      idx       <= '0;
      polls     <= '0;
      beat      <= '0;
      pend      <= 1'b0;
      failed    <= 1'b0;
      Busy      <= 1'b0;
      ByteStart <= 1'b0;
      ByteOut   <= 8'hFF;
      CardCS    <= 1'b1;
      DataOut   <= 8'h00;
      DataValid <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      ErrorCode <= 3'd0;
    end else begin
      ByteStart <= 1'b0;
      case (state)
        IDLE: begin
          pend <= 1'b0;
          if (ReadReq && InitDone && !Busy) begin
            addr      <= 32'(BlockAddr);
            ErrorCode <= 3'd0;
            Busy      <= 1'b1;
            CardCS    <= 1'b0;
            idx       <= '0;
            polls     <= '0;
            beat      <= '0;
            failed    <= 1'b0;
            state     <= CMD;
          end
        end
        CMD: begin
          if (!pend) begin
            ByteStart <= 1'b1;
            ByteOut   <= cmd_byte;
            pend      <= 1'b1;
          end else if (ByteDone) begin
            pend <= 1'b0;
            if (idx == 3'd5) begin
              idx   <= '0;
              polls <= '0;
              state <= R1WAIT;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        R1WAIT: begin
          if (!pend) begin
            ByteStart <= 1'b1;
            ByteOut   <= 8'hFF;
            pend      <= 1'b1;
          end else if (ByteDone) begin
            pend <= 1'b0;
            if (ByteIn == 8'hFF) begin
              if (polls == R1_LAST) begin
                ErrorCode <= 3'd2;
                failed    <= 1'b1;
                CardCS    <= 1'b1;
                state     <= TAIL;
              end else begin
                polls <= polls + 1'b1;
              end
            end else if (ByteIn == 8'h00) begin
              polls <= '0;
              state <= TOKWAIT;
            end else begin
              ErrorCode <= 3'd1;
              failed    <= 1'b1;
              CardCS    <= 1'b1;
              state     <= TAIL;
            end
          end
        end
        TOKWAIT: begin
          if (!pend) begin
            ByteStart <= 1'b1;
            ByteOut   <= 8'hFF;
            pend      <= 1'b1;
          end else if (ByteDone) begin
            pend <= 1'b0;
            if (ByteIn == 8'hFE) begin
              beat  <= '0;
              state <= DATA;
            end else if (ByteIn[7:4] == 4'h0) begin
              ErrorCode <= 3'd4;
              failed    <= 1'b1;
              CardCS    <= 1'b1;
              state     <= TAIL;
            end else if (polls == TOK_LAST) begin
              // any non-token, non-error reply counts as an idle poll
              ErrorCode <= 3'd3;
              failed    <= 1'b1;
              CardCS    <= 1'b1;
              state     <= TAIL;
            end else begin
              polls <= polls + 1'b1;
            end
          end
        end
        DATA: begin
          if (DataValid) begin
            if (DataReady) begin
              DataValid <= 1'b0;
              if (beat == LAST_BEAT) begin
                idx   <= '0;
                state <= CRC;
              end else begin
                beat <= beat + 1'b1;
              end
            end
          end else if (!pend) begin
            ByteStart <= 1'b1;
            ByteOut   <= 8'hFF;
            pend      <= 1'b1;
          end else if (ByteDone) begin
            pend      <= 1'b0;
            DataOut   <= ByteIn;
            DataValid <= 1'b1;
          end
        end
        CRC: begin
          if (!pend) begin
            ByteStart <= 1'b1;
            ByteOut   <= 8'hFF;
            pend      <= 1'b1;
          end else if (ByteDone) begin
            pend <= 1'b0;
            if (idx == 3'd1) begin
              CardCS <= 1'b1;
              state  <= TAIL;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        TAIL: begin
          if (!pend) begin
            ByteStart <= 1'b1;
            ByteOut   <= 8'hFF;
            pend      <= 1'b1;
          end else if (ByteDone) begin
            pend  <= 1'b0;
            Error <= failed;
            Done  <= !failed;
            state <= FIN;
          end
        end
        FIN: begin
          Done  <= 1'b0;
          Error <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
